pipe_hazard_unit: RTL and testbench

//  Parametrised forwarding/hazard controller for the in-order RISC-V pipeline. Replaces the fixed
//  5-stage forwarding control with a scoreboard of in-flight destination registers over DEPTH

---
 rtl/pipe_hazard_unit_if.sv | 47 ++++
 rtl/pipe_hazard_unit.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit_if
// Description : Decode-side request and hazard-control response bundle for
//               pipe_hazard_unit.
//               master = pipeline (drives id_* and ex_br_taken)
//               slave  = hazard unit (drives fwd_sel, stall_*, flush_*,
//                        stall_cnt)
// Ports       : id_valid, id_rs, id_rs_use, id_rd, id_rd_we, id_is_load,
//               ex_br_taken, fwd_sel, stall_if, stall_id, flush_id,
//               flush_ex, stall_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_unit_if #(
    parameter int REGW  = 5,
    parameter int NSRC  = 2,
    parameter int DEPTH = 3,
    parameter int CNTW  = 16
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic                   id_valid;
    logic [NSRC*REGW-1:0]   id_rs;
    logic [NSRC-1:0]        id_rs_use;
    logic [REGW-1:0]        id_rd;
    logic                   id_rd_we;
    logic                   id_is_load;
    logic                   ex_br_taken;

    logic [NSRC*SELW-1:0]   fwd_sel;
    logic                   stall_if;
    logic                   stall_id;
    logic                   flush_id;
    logic                   flush_ex;
    logic [CNTW-1:0]        stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_use, id_rd, id_rd_we, id_is_load, ex_br_taken,
        input  fwd_sel, stall_if, stall_id, flush_id, flush_ex, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_use, id_rd, id_rd_we, id_is_load, ex_br_taken,
        output fwd_sel, stall_if, stall_id, flush_id, flush_ex, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Scoreboard-based forwarding / load-use / branch-flush
//               controller for an in-order pipeline. Tracks DEPTH
//               post-decode stages (entry 0 = EX ... entry DEPTH-1 = WB).
// Ports       : clk    - pipeline clock, rising edge
//               rst_n  - asynchronous active-low reset
//               hz     - pipe_hazard_unit_if.slave (decode request in,
//                        forward selects / stalls / flushes / counter out)
// Parameters  : LOAD_READY must lie in 1..DEPTH-1.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int REGW       = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int CNTW       = 16,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    pipe_hazard_unit_if.slave hz
);

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]   v_q,  v_d;
    logic [DEPTH-1:0]   we_q, we_d;
    logic [DEPTH-1:0]   ld_q, ld_d;
    logic [REGW-1:0]    rd_q [DEPTH];
    logic [REGW-1:0]    rd_d [DEPTH];
    logic [CNTW-1:0]    stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // Per-operand youngest-match search
    // ------------------------------------------------------------------
    logic [SELW-1:0]    w_fwd [NSRC];
    logic [NSRC-1:0]    w_lu;
    logic               w_load_use;
    logic               w_flush;
    logic               w_stall;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_fwd[i] = '0;
            w_lu[i]  = 1'b0;
            // Scan oldest to youngest so the lowest matching k is the last
            // assignment and therefore the one that sticks.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (hz.id_valid && hz.id_rs_use[i] && v_q[k] && we_q[k] &&
                    (rd_q[k] == hz.id_rs[i*REGW +: REGW]) &&
                    (hz.id_rs[i*REGW +: REGW] != '0)) begin
                    if (!ld_q[k] || (k >= LOAD_READY)) begin
                        w_fwd[i] = SELW'(k + 1);
                        w_lu[i]  = 1'b0;
                    end else begin
                        w_fwd[i] = '0;
                        w_lu[i]  = 1'b1;
                    end
                end
            end
        end
    end

    assign w_load_use = |w_lu;
    assign w_flush    = hz.ex_br_taken;
    // A taken branch makes the decoded instruction wrong-path, so its
    // load-use hazard is irrelevant.
    assign w_stall    = w_load_use && !w_flush;

    // ------------------------------------------------------------------
    // Outputs: forced low while reset is asserted (asynchronously)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_fwd_pack
        assign hz.fwd_sel[gi*SELW +: SELW] = rst_n ? w_fwd[gi] : '0;
    end

    assign hz.stall_if  = rst_n && w_stall;
    assign hz.stall_id  = rst_n && w_stall;
    assign hz.flush_id  = rst_n && w_flush;
    assign hz.flush_ex  = rst_n && w_flush;
    assign hz.stall_cnt = stall_cnt_q;

    // ------------------------------------------------------------------
    // Next-state: shift the pipe, insert decode or a bubble at entry 0
    // ------------------------------------------------------------------
    always_comb begin
        v_d  = '0;
        we_d = '0;
        ld_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rd_d[k] = '0;
        end

        for (int k = 1; k < DEPTH; k++) begin
            v_d[k]  = v_q[k-1];
            we_d[k] = we_q[k-1];
            ld_d[k] = ld_q[k-1];
            rd_d[k] = rd_q[k-1];
        end

        if (!(w_load_use || w_flush)) begin
            v_d[0]  = hz.id_valid;
            we_d[0] = hz.id_rd_we;
            ld_d[0] = hz.id_is_load;
            rd_d[0] = hz.id_rd;
        end

        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            we_q        <= '0;
            ld_q        <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            v_q         <= v_d;
            we_q        <= we_d;
            ld_q        <= ld_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= rd_d[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_unit
// Description : Directed self-checking bench for pipe_hazard_unit. Instance
//               A uses default parameters; instance B uses DEPTH=4,
//               LOAD_READY=3, CNTW=2 for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errs   = 0;

    pipe_hazard_unit_if #(.REGW(5), .NSRC(2), .DEPTH(3), .CNTW(16)) ifa ();
    pipe_hazard_unit_if #(.REGW(5), .NSRC(2), .DEPTH(4), .CNTW(2))  ifb ();

    pipe_hazard_unit #(.REGW(5), .NSRC(2), .DEPTH(3), .LOAD_READY(2), .CNTW(16)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifa)
    );

    pipe_hazard_unit #(.REGW(5), .NSRC(2), .DEPTH(4), .LOAD_READY(3), .CNTW(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive decode of instance A: rs1/rs0, use={use1,use0}
    task automatic drv_a(input bit v, input logic [4:0] rs1, input logic [4:0] rs0,
                         input logic [1:0] use_m, input logic [4:0] rd, input bit we,
                         input bit ld, input bit br);
        ifa.id_valid    = v;
        ifa.id_rs       = {rs1, rs0};
        ifa.id_rs_use   = use_m;
        ifa.id_rd       = rd;
        ifa.id_rd_we    = we;
        ifa.id_is_load  = ld;
        ifa.ex_br_taken = br;
    endtask

    task automatic drv_b(input bit v, input logic [4:0] rs0, input logic [1:0] use_m,
                         input logic [4:0] rd, input bit we, input bit ld);
        ifb.id_valid    = v;
        ifb.id_rs       = {5'd0, rs0};
        ifb.id_rs_use   = use_m;
        ifb.id_rd       = rd;
        ifb.id_rd_we    = we;
        ifb.id_is_load  = ld;
        ifb.ex_br_taken = 1'b0;
    endtask

    // Advance one cycle; returns 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
        drv_b(0, 0, 2'b00, 0, 0, 0);
        #2;
        check("rst_fwd",   32'(ifa.fwd_sel),   0);
        check("rst_stall", 32'(ifa.stall_id),  0);
        check("rst_cnt",   32'(ifa.stall_cnt), 0);
        tick();
        rst_n = 1'b1;

        // ---- 1: ALU chain ----
        drv_a(1, 5'd2, 5'd1, 2'b11, 5'd5, 1, 0, 0);        // add x5,x1,x2
        #1 check("alu_first_fwd", 32'(ifa.fwd_sel), 0);
        tick();
        drv_a(1, 5'd1, 5'd5, 2'b11, 5'd6, 1, 0, 0);        // sub x6,x5,x1
        #1 check("alu_fwd_ex",   32'(ifa.fwd_sel),  32'h1);
        check("alu_stall",       32'(ifa.stall_id), 0);
        tick();
        drv_a(1, 0, 0, 2'b00, 5'd10, 1, 0, 0);             // unrelated
        tick();
        drv_a(1, 5'd6, 5'd5, 2'b11, 5'd0, 0, 0, 0);        // x5 in WB, x6 in MEM
        #1 check("alu_fwd_wb_mem", 32'(ifa.fwd_sel), {28'd0, 2'd2, 2'd3});
        tick();

        // ---- 2: load-use with one intervening instruction ----
        drv_a(1, 0, 0, 2'b00, 5'd7, 1, 1, 0);              // lw x7
        tick();
        drv_a(1, 0, 0, 2'b00, 5'd11, 1, 0, 0);             // unrelated
        tick();
        drv_a(1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 0, 0);        // add x8,x7,x7
        #1 check("lu_stall_if",  32'(ifa.stall_if), 1);
        check("lu_stall_id",     32'(ifa.stall_id), 1);
        check("lu_fwd_blocked",  32'(ifa.fwd_sel),  0);
        tick();
        #1 check("lu_released",  32'(ifa.stall_id), 0);
        check("lu_fwd_wb",       32'(ifa.fwd_sel),  32'hF);
        check("lu_cnt",          32'(ifa.stall_cnt), 1);
        tick();

        // ---- 3: x0 and unused operands ----
        drv_a(1, 0, 0, 2'b00, 5'd0, 1, 0, 0);              // write x0
        tick();
        drv_a(1, 5'd0, 5'd0, 2'b11, 5'd0, 0, 0, 0);        // read x0
        #1 check("x0_fwd",   32'(ifa.fwd_sel),  0);
        check("x0_stall",    32'(ifa.stall_id), 0);
        tick();
        drv_a(1, 0, 5'd8, 2'b00, 5'd0, 0, 0, 0);           // x8 in WB, not used
        #1 check("unused_fwd", 32'(ifa.fwd_sel), 0);
        drv_a(1, 0, 5'd8, 2'b01, 5'd0, 0, 0, 0);
        #1 check("used_fwd",   32'(ifa.fwd_sel), 32'h3);
        tick();

        // ---- 4: youngest wins, flush beats load-use ----
        drv_a(1, 0, 0, 2'b00, 5'd9, 1, 0, 0);
        tick();
        drv_a(1, 0, 0, 2'b00, 5'd9, 1, 0, 0);
        tick();
        drv_a(1, 0, 5'd9, 2'b01, 5'd0, 0, 0, 0);
        #1 check("youngest_fwd", 32'(ifa.fwd_sel), 32'h1);
        tick();
        drv_a(1, 0, 0, 2'b00, 5'd12, 1, 1, 0);             // lw x12
        tick();
        drv_a(1, 0, 5'd12, 2'b01, 5'd13, 1, 0, 1);         // use + taken branch
        #1 check("flush_id",  32'(ifa.flush_id), 1);
        check("flush_ex",     32'(ifa.flush_ex), 1);
        check("flush_nostall", 32'(ifa.stall_if), 0);
        tick();
        drv_a(1, 0, 5'd13, 2'b01, 5'd0, 0, 0, 0);          // x13 must be a bubble
        #1 check("flush_bubble", 32'(ifa.fwd_sel), 0);
        check("flush_cnt_hold",  32'(ifa.stall_cnt), 1);
        check("flush_clear",     32'(ifa.flush_id), 0);
        tick();

        // ---- immediate load-use: two stall cycles ----
        drv_a(1, 0, 0, 2'b00, 5'd14, 1, 1, 0);             // lw x14
        tick();
        drv_a(1, 0, 5'd14, 2'b01, 5'd0, 0, 0, 0);
        #1 check("lu2_stall_c1", 32'(ifa.stall_id), 1);
        tick();
        #1 check("lu2_stall_c2", 32'(ifa.stall_id), 1);
        check("lu2_cnt",         32'(ifa.stall_cnt), 2);

        // ---- 5: async reset mid-stall ----
        ifa.ex_br_taken = 1'b1;
        rst_n = 1'b0;
        #1 check("ar_stall_if", 32'(ifa.stall_if),  0);
        check("ar_stall_id",    32'(ifa.stall_id),  0);
        check("ar_flush",       32'(ifa.flush_id),  0);
        check("ar_fwd",         32'(ifa.fwd_sel),   0);
        check("ar_cnt",         32'(ifa.stall_cnt), 0);
        ifa.ex_br_taken = 1'b0;
        rst_n = 1'b1;
        #1 check("post_rst_stall", 32'(ifa.stall_id), 0);
        check("post_rst_fwd",      32'(ifa.fwd_sel),  0);
        tick();
        #1 check("post_rst_fwd2",  32'(ifa.fwd_sel),  0);
        drv_a(0, 0, 0, 2'b00, 0, 0, 0, 0);

        // ---- 6: instance B, counter saturation ----
        drv_b(1, 0, 2'b00, 5'd20, 1, 1);                   // lw x20
        tick();
        drv_b(1, 5'd20, 2'b01, 5'd21, 1, 0);               // immediate use
        #1 check("b_stall1", 32'(ifb.stall_id),  1);
        check("b_cnt0",      32'(ifb.stall_cnt), 0);
        tick();
        #1 check("b_stall2", 32'(ifb.stall_id),  1);
        check("b_cnt1",      32'(ifb.stall_cnt), 1);
        tick();
        #1 check("b_stall3", 32'(ifb.stall_id),  1);
        check("b_cnt2",      32'(ifb.stall_cnt), 2);
        tick();
        #1 check("b_release", 32'(ifb.stall_id), 0);
        check("b_fwd_wb",     32'(ifb.fwd_sel),  32'h4);
        check("b_cnt3",       32'(ifb.stall_cnt), 3);
        tick();
        drv_b(1, 0, 2'b00, 5'd22, 1, 1);                   // lw x22
        tick();
        drv_b(1, 5'd22, 2'b01, 5'd23, 1, 0);
        for (int c = 0; c < 3; c++) begin
            #1 check("b_sat_stall", 32'(ifb.stall_id),  1);
            check("b_sat_cnt",      32'(ifb.stall_cnt), 3);
            tick();
        end
        #1 check("b_sat_release", 32'(ifb.stall_id),  0);
        check("b_sat_final",      32'(ifb.stall_cnt), 3);
        drv_b(0, 0, 2'b00, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
